// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner: column scan, tick-sampled debounce,
// key decode and a four-digit entry display shift register.
module keypad_entry #(
   parameter int SCAN_W = 16,
   parameter int DEB_N  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic [15:0] nums
);

   localparam int CW = $clog2(DEB_N + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_N - 1);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD
   } state_t;

   state_t        state, state_n;
   logic [3:0]    row_m, row_s;
   logic [SCAN_W-1:0] div;
   logic [1:0]    col_idx, col_idx_n;
   logic [3:0]    cand, cand_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    code_n;
   logic          valid_n;
   logic [15:0]   nums_n;
   logic          tick;
   logic          any_low;
   logic [1:0]    row_idx;
   logic [3:0]    p_now;

   function automatic logic [3:0] key_of(input logic [3:0] p);
      logic [3:0] k;
      case (p)
         4'd0:    k = 4'h1;
         4'd1:    k = 4'h2;
         4'd2:    k = 4'h3;
         4'd3:    k = 4'hA;
         4'd4:    k = 4'h4;
         4'd5:    k = 4'h5;
         4'd6:    k = 4'h6;
         4'd7:    k = 4'hB;
         4'd8:    k = 4'h7;
         4'd9:    k = 4'h8;
         4'd10:   k = 4'h9;
         4'd11:   k = 4'hC;
         4'd12:   k = 4'hE;
         4'd13:   k = 4'h0;
         4'd14:   k = 4'hF;
         default: k = 4'hD;
      endcase
      return k;
   endfunction

   function automatic logic [15:0] nums_upd(
      input logic [15:0] n,
      input logic [3:0]  k
   );
      logic [15:0] r;
      r = n;
      if (k <= 4'd9)
         r = {n[11:0], k};
      else if (k == 4'hC)
         r = 16'hAAAA;
      else if (k == 4'hA)
         r = {4'hA, n[15:4]};
      return r;
   endfunction

   assign tick    = &div;
   assign any_low = ~&row_s;
   assign col     = ~(4'b0001 << col_idx);
   assign p_now   = {row_idx, col_idx};

   // lowest-index low row wins
   always_comb begin
      row_idx = 2'd3;
      if (!row_s[0])
         row_idx = 2'd0;
      else if (!row_s[1])
         row_idx = 2'd1;
      else if (!row_s[2])
         row_idx = 2'd2;
   end

   always_comb begin
      state_n   = state;
      col_idx_n = col_idx;
      cand_n    = cand;
      cnt_n     = cnt;
      code_n    = key_code;
      valid_n   = 1'b0;
      nums_n    = nums;
      if (tick) begin
         unique case (state)
            SCAN: begin
               if (any_low) begin
                  cand_n  = p_now;
                  cnt_n   = CW'(1);
                  state_n = DEBOUNCE;
               end else begin
                  col_idx_n = col_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (any_low && p_now == cand) begin
                  if (cnt == DEB_LAST) begin
                     valid_n = 1'b1;
                     code_n  = key_of(cand);
                     nums_n  = nums_upd(nums, key_of(cand));
                     cnt_n   = '0;
                     state_n = HELD;
                  end else begin
                     cnt_n = cnt + 1'b1;
                  end
               end else begin
                  cnt_n     = '0;
                  col_idx_n = col_idx + 2'd1;
                  state_n   = SCAN;
               end
            end
            HELD: begin
               if (any_low) begin
                  cnt_n = '0;
               end else if (cnt == DEB_LAST) begin
                  cnt_n     = '0;
                  col_idx_n = col_idx + 2'd1;
                  state_n   = SCAN;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: state_n = SCAN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_m     <= 4'b1111;
         row_s     <= 4'b1111;
         div       <= '0;
         state     <= SCAN;
         col_idx   <= 2'd0;
         cand      <= 4'd0;
         cnt       <= '0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         nums      <= 16'hAAAA;
      end else begin
         row_m     <= row;
         row_s     <= row_m;
         div       <= div + 1'b1;
         state     <= state_n;
         col_idx   <= col_idx_n;
         cand      <= cand_n;
         cnt       <= cnt_n;
         key_code  <= code_n;
         key_valid <= valid_n;
         nums      <= nums_n;
      end
   end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The block SHALL have parameter SCAN_W, default 16, meaning each column dwell is 2^SCAN_W clocks; one "tick" is the last clock of a dwell.
REQ-002 The block SHALL have parameter DEB_N, default 4, meaning the number of consecutive matching tick samples required for press or release acceptance.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port row, input, 4 bits: keypad rows, active-low, pulled up externally, asynchronous to clk.
REQ-006 The block SHALL have port col, output, 4 bits: keypad column drive, active-low one-hot.
REQ-007 The block SHALL have port key_code, output, 4 bits: decoded value of the last accepted key.
REQ-008 The block SHALL have port key_valid, output, 1 bit: one-clock pulse per accepted press.
REQ-009 The block SHALL have port nums, output, 16 bits: four 4-bit display digits, digit0 at [3:0]; value 4'hA means dash.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value only.
REQ-011 A free-running SCAN_W-bit divider SHALL count every clock; row is sampled only at a tick.
REQ-012 The FSM SHALL have states SCAN, DEBOUNCE and HELD.
REQ-013 SCAN: at a tick with all rows high, col SHALL rotate 1110->1101->1011->0111->1110.
REQ-014 SCAN: at a tick with any row low, the FSM SHALL latch candidate position p=4*r+c (r = lowest-index low row, c = active column index), set count=1, enter DEBOUNCE, and hold col.
REQ-015 DEBOUNCE: at each tick, the same p SHALL increment count; when count reaches DEB_N the FSM SHALL pulse key_valid, update key_code and nums, and enter HELD.
REQ-016 DEBOUNCE: at a tick with a different p or no row low, the FSM SHALL return to SCAN and advance col one step, with no output change.
REQ-017 HELD: col SHALL stay fixed; DEB_N consecutive ticks with all rows high SHALL return the FSM to SCAN and advance col; any row-low tick SHALL reset the release count; no repeat keys SHALL be produced.
REQ-018 Position decode p0..p15 SHALL be 1,2,3,A,4,5,6,B,7,8,9,C,E,0,F,D.
REQ-019 A key of value 0-9 SHALL set nums <= {nums[11:0], key}.
REQ-020 Key C SHALL set nums <= 16'hAAAA.
REQ-021 Key A (backspace) SHALL set nums <= {4'hA, nums[15:4]}.
REQ-022 Keys B, D, E and F SHALL pulse key_valid and update key_code but SHALL leave nums unchanged.
REQ-023 key_valid SHALL be high for exactly one clock, in the clock after the accepting tick; key_code and nums SHALL update in that same clock.
REQ-024 The latency from a stable press first being visible at the synchronizer output to key_valid SHALL be at most (DEB_N+4)*2^SCAN_W + 3 clocks.
REQ-025 Simultaneous presses in different rows of the active column SHALL resolve to the lowest row index; presses in other columns SHALL be ignored until the FSM returns to SCAN.

Reset
REQ-026 While rst=0 the block SHALL asynchronously force: col=4'b1110, key_code=4'h0, key_valid=0, nums=16'hAAAA, FSM=SCAN, divider=0, debounce count=0, synchronizer flops=4'b1111.
REQ-027 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort the operation with no key_valid pulse; after deassertion, scanning SHALL restart at column 0 at the first tick.

Verification (SCAN_W=2, DEB_N=3)
REQ-028 Idle: rows all high after reset -> col cycles 1110,1101,1011,0111 with 4 clocks per column; key_valid stays 0; nums stays AAAA.
REQ-029 Press row1 while col=1101 (key 5), held 40 clocks -> exactly one key_valid pulse, key_code=5, nums=AAA5; after release, scanning resumes.
REQ-030 Press key 1 -> 2 -> 3 -> 4 -> 0 in sequence -> nums=2340; then key A -> nums=A234; then key C -> nums=AAAA.
REQ-031 A bounce of 1 tick low then high on any row -> no key_valid pulse; col advances from the column where the bounce occurred.
REQ-032 Rows 0 and 2 low together in column 2 -> key_code=3 (row 0 wins).
REQ-033 rst=0 asserted during HELD -> col=1110, nums=AAAA and key_valid=0 immediately; no pulse after rst returns to 1 while the key is still held until the full debounce completes.
